// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: single-cycle core port with priority over a DMA word-burst port.
// Optional starvation override enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH    = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [2:0]            c_funct3,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_gnt,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LEN_WIDTH-1:0]  d_len,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_wnext,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  m_wr_en,
    output logic [2:0]            m_funct3,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, ACCEPT, BURST, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  we_q;
    logic                  force_dma;
    logic                  core_win;
    logic                  beat;

    assign core_win = c_req & ~force_dma;
    assign beat     = (state_q == BURST) & ~core_win;
    assign c_gnt    = core_win;
    assign c_rdata  = m_rdata;
    assign d_wnext  = beat & we_q;

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q;
    logic                unused_bits;

    assign force_dma   = (state_q == BURST) && (starve_q == STARVE_W'(STARVE_LIMIT));
    assign unused_bits = ^d_addr[1:0];

    // Consecutive BURST cycles lost to the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if ((state_q != BURST) || beat) begin
            starve_q <= '0;
        end else if (core_win) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end
`else
    logic unused_bits;

    assign force_dma   = 1'b0;
    assign unused_bits = ^{d_addr[1:0], 32'(STARVE_LIMIT)};
`endif

    // Next state and memory-side mux
    always_comb begin
        state_d  = state_q;
        m_wr_en  = 1'b0;
        m_funct3 = FUNCT3_WORD;
        m_addr   = '0;
        m_wdata  = '0;

        case (state_q)
            IDLE:    if (d_req) state_d = ACCEPT;
            ACCEPT:  state_d = (cnt_q == '0) ? DONE : BURST;
            BURST:   if (beat && (cnt_q == LEN_WIDTH'(1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (core_win) begin
            m_wr_en  = c_we;
            m_funct3 = c_funct3;
            m_addr   = c_addr;
            m_wdata  = c_wdata;
        end else if (beat) begin
            m_wr_en  = we_q;
            m_addr   = addr_q;
            m_wdata  = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst context: captured when the request is sampled, advanced per executed beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
        end else if ((state_q == IDLE) && d_req) begin
            addr_q <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
            cnt_q  <= d_len;
            we_q   <= d_we;
        end else if (beat) begin
            addr_q <= addr_q + ADDR_WIDTH'(4);
            cnt_q  <= cnt_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_gnt    <= 1'b0;
            d_done   <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            d_gnt    <= (state_d == ACCEPT);
            d_done   <= (state_d == DONE);
            d_rvalid <= beat & ~we_q;
            if (beat && !we_q) begin
                d_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, burst corner cases and
// randomized bursts with core contention against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 5;
    localparam int unsigned SL = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [2:0]    c_funct3 = 3'b010;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt;
    logic [DW-1:0] c_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_len = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_wnext, d_rvalid, d_done;
    logic [DW-1:0] d_rdata;
    logic          m_wr_en;
    logic [2:0]    m_funct3;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_wnext(d_wnext),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .m_wr_en(m_wr_en), .m_funct3(m_funct3), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Physical memory driven by the DUT's memory port (256 words, aliased)
    logic [DW-1:0] mem [256];
    always @(posedge clk) if (m_wr_en) mem[m_addr[9:2]] <= m_wdata;
    assign m_rdata = mem[m_addr[9:2]];

    // Expected memory contents; ref_ok marks words whose value is known
    logic [DW-1:0] ref_mem [256];
    bit            ref_ok  [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_gnt;
        bit          exp_wr;
        logic [31:0] exp_maddr;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] data);
        ref_mem[addr[9:2]] = data;
        ref_ok[addr[9:2]]  = 1'b1;
    endtask

    task automatic core_drive(input bit req);
        c_req    = req;
        c_we     = 1'($urandom_range(1));
        c_funct3 = 3'b010;
        c_addr   = {22'd0, 8'($urandom_range(255)), 2'b00};
        c_wdata  = $urandom;
    endtask

    task automatic idle_mem_check();
        chk("idle_m_wr_en", m_wr_en, 0);
        chk("idle_m_addr", m_addr, 0);
        chk("idle_m_funct3", m_funct3, 3'b010);
        chk("idle_m_wdata", m_wdata, 0);
    endtask

    // Checks the core side given whether the core is expected to win this cycle
    task automatic core_check(input bit exp_gnt);
        chk("c_gnt", c_gnt, exp_gnt);
        if (exp_gnt) begin
            chk("core_m_wr_en", m_wr_en, c_we);
            chk("core_m_addr", m_addr, c_addr);
            chk("core_m_funct3", m_funct3, c_funct3);
            if (c_we) begin
                chk("core_m_wdata", m_wdata, c_wdata);
                ref_write(c_addr, c_wdata);
            end else if (ref_ok[c_addr[9:2]]) begin
                chk("c_rdata", c_rdata, ref_mem[c_addr[9:2]]);
            end
        end
    endtask

    // One burst from request to the idle cycle after DONE, with core traffic
    task automatic dma_burst(input bit we, input logic [31:0] addr, input int len,
                             input int pct, input int hold);
        logic [31:0] base, baddr, wd, exp_rd;
        int          beats, lost, k;
        bit          cr, cw, exp_rv, rd_known;
        base  = {addr[31:2], 2'b00};
        beats = 0;
        lost  = 0;
        k     = 0;
        exp_rv = 1'b0;
        rd_known = 1'b0;
        exp_rd = '0;
        wd    = $urandom;

        next_cycle();
        core_drive(1'b0);
        d_req = 1'b1; d_we = we; d_addr = addr; d_len = LW'(len); d_wdata = wd;
        @(negedge clk);
        chk("req_d_gnt", d_gnt, 0);
        idle_mem_check();

        next_cycle();
        d_req = 1'b0;
        cr = 1'($urandom_range(1));
        core_drive(cr);
        @(negedge clk);
        chk("accept_d_gnt", d_gnt, 1);
        chk("accept_d_done", d_done, 0);
        chk("accept_d_rvalid", d_rvalid, 0);
        core_check(cr);
        if (!cr) idle_mem_check();

        while (beats < len && k < 300) begin
            next_cycle();
            d_addr = $urandom; d_len = LW'($urandom); d_we = ~we; d_wdata = wd;
            d_req = 1'($urandom_range(1));
            cr = (k < hold) ? 1'b1 : ($urandom_range(99) < pct);
            core_drive(cr);
            cw = cr && !(STARVE_EN && lost == int'(SL));
            @(negedge clk);
            chk("burst_d_gnt", d_gnt, 0);
            chk("burst_d_done", d_done, 0);
            chk("burst_d_rvalid", d_rvalid, exp_rv);
            if (exp_rv && rd_known) chk("burst_d_rdata", d_rdata, exp_rd);
            core_check(cw);
            exp_rv = 1'b0;
            if (!cw) begin
                baddr = base + 32'(4 * beats);
                chk("beat_m_addr", m_addr, baddr);
                chk("beat_m_wr_en", m_wr_en, we);
                chk("beat_m_funct3", m_funct3, 3'b010);
                chk("beat_d_wnext", d_wnext, we);
                if (we) begin
                    chk("beat_m_wdata", m_wdata, wd);
                    ref_write(baddr, wd);
                    wd = $urandom;
                end else begin
                    exp_rv   = 1'b1;
                    rd_known = ref_ok[baddr[9:2]];
                    exp_rd   = ref_mem[baddr[9:2]];
                end
                beats++;
                lost = 0;
            end else begin
                chk("stall_d_wnext", d_wnext, 0);
                lost++;
            end
            k++;
        end
        if (beats < len) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: beats %0d required %0d", beats, len);
        end

        next_cycle();
        d_req = 1'b0;
        cr = 1'($urandom_range(1));
        core_drive(cr);
        @(negedge clk);
        chk("done_d_done", d_done, 1);
        chk("done_d_gnt", d_gnt, 0);
        chk("done_d_wnext", d_wnext, 0);
        chk("done_d_rvalid", d_rvalid, exp_rv);
        if (exp_rv && rd_known) chk("done_d_rdata", d_rdata, exp_rd);
        core_check(cr);
        if (!cr) idle_mem_check();

        next_cycle();
        core_drive(1'b0);
        @(negedge clk);
        chk("post_d_done", d_done, 0);
        chk("post_d_rvalid", d_rvalid, 0);
    endtask

    task automatic core_op(input bit we, input logic [31:0] addr, input logic [31:0] data);
        next_cycle();
        c_req = 1'b1; c_we = we; c_funct3 = 3'b010; c_addr = addr; c_wdata = data;
        @(negedge clk);
        core_check(1'b1);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h10, 1'b1, 32'hCAFEF00D};
        vt[2] = '{1'b0, 1'b1, 32'h10, 32'hDEAD,     1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        vt[3] = '{1'b1, 1'b1, 32'h14, 32'h12345678, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0};
        vt[4] = '{1'b1, 1'b0, 32'h14, 32'h0,        1'b1, 1'b0, 32'h14, 1'b1, 32'h12345678};
        vt[5] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h10, 1'b1, 32'hCAFEF00D};

        #1 rst_n = 1'b0;
        #10;
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_d_wnext", d_wnext, 0);
        chk("rst_c_gnt", c_gnt, 0);
        idle_mem_check();
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            next_cycle();
            c_req = vt[i].req; c_we = vt[i].we; c_funct3 = 3'b010;
            c_addr = vt[i].addr; c_wdata = vt[i].wdata;
            @(negedge clk);
            chk("vec_c_gnt", c_gnt, vt[i].exp_gnt);
            chk("vec_m_wr_en", m_wr_en, vt[i].exp_wr);
            chk("vec_m_addr", m_addr, vt[i].exp_maddr);
            if (vt[i].chk_rd) chk("vec_c_rdata", c_rdata, vt[i].exp_rd);
            if (vt[i].req && vt[i].we) ref_write(vt[i].addr, vt[i].wdata);
        end

        dma_burst(1'b1, 32'h20, 3, 0, 0);
        dma_burst(1'b0, 32'h20, 3, 0, 0);
        dma_burst(1'b1, 32'h33, 0, 0, 0);
        dma_burst(1'b1, 32'hFFFFFFFC, 2, 0, 0);
        dma_burst(1'b0, 32'hFFFFFFFE, 2, 0, 0);
        dma_burst(1'b1, 32'h80, 4, 0, 12);
        dma_burst(1'b0, 32'h80, 4, 0, 12);

        // Reset during beat 2 of a 4-beat write burst
        core_op(1'b1, 32'h44, 32'h0BADF00D);
        next_cycle();
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_len = 5'd4; d_wdata = 32'hA5A50001;
        next_cycle();
        d_req = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rb_beat1_wr", m_wr_en, 1);
        chk("rb_beat1_addr", m_addr, 32'h40);
        ref_write(32'h40, 32'hA5A50001);
        next_cycle();
        d_wdata = 32'hA5A50002;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rb_d_gnt", d_gnt, 0);
        chk("rb_d_done", d_done, 0);
        chk("rb_d_rvalid", d_rvalid, 0);
        chk("rb_d_rdata", d_rdata, 0);
        chk("rb_d_wnext", d_wnext, 0);
        idle_mem_check();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clk);
            chk("rb_after_d_done", d_done, 0);
            chk("rb_after_wr", m_wr_en, 0);
        end
        core_op(1'b0, 32'h44, 32'h0);
        core_op(1'b0, 32'h40, 32'h0);

        for (int n = 0; n < 25; n++) begin
            dma_burst(1'($urandom_range(1)), $urandom, int'($urandom_range(31)),
                      int'($urandom_range(80)), int'($urandom_range(6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the core load/store path and a word-burst DMA/loader port. Core accesses are single-cycle and combinational, so the single-cycle core needs no pipeline change beyond a stall on `c_gnt` low. DMA accesses are multi-word bursts sequenced by an internal FSM in cycles the core leaves free. The block sits between the core, the DMA engine and the data memory, and drives the memory's `wr_en`/`funct3`/address/write-data inputs.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width
- `LEN_WIDTH`, 5, burst-length field width; maximum burst is 2^LEN_WIDTH-1 words
- `STARVE_LIMIT`, 4, consecutive stalled DMA beats before the DMA is forced through (macro-dependent)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `c_req`  in  1  core access request
- `c_we`  in  1  core write (1) / read (0)
- `c_funct3`  in  3  load/store size code, passed to memory unchanged
- `c_addr`  in  ADDR_WIDTH  core byte address
- `c_wdata`  in  DATA_WIDTH  core store data
- `c_gnt`  out  1  core access performed this cycle; core stalls while `c_req & ~c_gnt`
- `c_rdata`  out  DATA_WIDTH  `m_rdata` passed through; valid in the `c_gnt` cycle
- `d_req`  in  1  burst request
- `d_we`  in  1  burst direction
- `d_addr`  in  ADDR_WIDTH  burst start address; bits [1:0] ignored
- `d_len`  in  LEN_WIDTH  burst length in words
- `d_wdata`  in  DATA_WIDTH  current write-beat data
- `d_gnt`  out  1  one-cycle pulse: burst accepted
- `d_wnext`  out  1  write beat performed this cycle; `d_wdata` consumed
- `d_rvalid`  out  1  registered read beat valid
- `d_rdata`  out  DATA_WIDTH  registered read data
- `d_done`  out  1  one-cycle pulse: burst complete
- `m_wr_en`, `m_funct3`, `m_addr`, `m_wdata`  out  memory-side controls
- `m_rdata`  in  DATA_WIDTH  combinational memory read data

## Operation
- FSM states:
  - IDLE: sample `d_req`.
  - ACCEPT: latch `d_addr`, `d_len`, `d_we`; pulse `d_gnt`.
  - BURST: run the beats.
  - DONE: pulse `d_done`; return to IDLE.
- `d_len==0`: goes ACCEPT→DONE with no memory access.
- Beat counter loads `d_len`, decrements per executed beat; the last beat (counter==1) moves to DONE.
- Beat address: aligned latched address, +4 per beat, wrapping modulo 2^ADDR_WIDTH.
- DMA beats always use `m_funct3=3'b010`.
- Per-cycle arbitration in every state: the core wins whenever `c_req`=1, except under the starvation override (Configuration). In BURST, a DMA beat executes only in cycles the core does not win.
- Memory mux:
  - Core selected: `m_* = c_*`, `m_wr_en = c_we`.
  - DMA beat: `m_wr_en = d_we`, `m_addr` = beat address, `m_wdata = d_wdata`.
  - Otherwise: `m_wr_en=0`, `m_addr=0`, `m_funct3=3'b010`, `m_wdata=0`.
- `c_gnt`, `d_wnext` and the `m_*` outputs are combinational from state and requests.
- `d_rvalid`/`d_rdata` are registered from a DMA read beat.
- `d_req` is ignored outside IDLE.

## Timing
- Reset (async assert): state IDLE, counters 0, all registered outputs 0. Combinational outputs settle to the idle values above.
- Reset mid-burst: aborts immediately. No further writes; no `d_done` pulse.
- Core latency is 0: write commits at the edge ending the `c_gnt` cycle; `c_rdata` is valid in the same cycle.
- DMA:
  - `d_req` high in IDLE at edge N → `d_gnt` high in cycle N+1 (ACCEPT).
  - First beat can occur in cycle N+2.
  - A burst of L words with no core contention finishes beats in cycles N+2..N+1+L; `d_done` is high in cycle N+2+L.
- Read beat in cycle k → `d_rvalid`/`d_rdata` in cycle k+1. The last read's `d_rvalid` coincides with `d_done`.
- The cycle after DONE is IDLE; a new `d_req` is sampled there.
- A stalled beat holds its address and counter; `d_wdata` must be held until `d_wnext`.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - A counter tracks consecutive BURST cycles lost to the core.
  - When the counter reaches `STARVE_LIMIT`, the next cycle runs the DMA beat, holds `c_gnt` low, and clears the counter.
  - Any executed beat also clears the counter.
- Not defined: strict core priority. The counter logic is absent, and `STARVE_LIMIT` is unused.

## Test plan
- Core `sw` to 0x10, then `lw` from 0x10 with `d_req=0` → `c_gnt=1` both cycles, `c_rdata=wdata`, `m_wr_en` mirrors `c_we`.
- DMA write, `d_addr=0x20`, `d_len=3`, no core activity → `d_gnt` cycle 1, `d_wnext` cycles 2-4 at addresses 0x20/0x24/0x28, `d_done` cycle 5.
- DMA read of the same 3 words → `d_rvalid` in cycles 3-5 with the written data; `d_done` in cycle 5.
- With `STARVE_EN`, `STARVE_LIMIT=4`, `c_req` held high during a burst → 4 core grants, then 1 cycle with `c_gnt=0` and a DMA beat; the pattern repeats. Without the macro, the burst stalls until `c_req` drops.
- `d_len=0` → `d_gnt` then `d_done` one cycle later, `m_wr_en` never high. `d_addr=0xFFFFFFFC`, `d_len=2` → beat addresses 0xFFFFFFFC then 0x0.
- `rst_n` low during beat 2 of 4 → outputs return to reset values, no further `m_wr_en`, no `d_done`.
